// File: rtl/dual_down_counter.sv
// Dual-channel loadable down-counter with terminal-count pulses.
// Channel 0 steps every enabled cycle; channel 1 steps once per PRESCALE enabled cycles.
module dual_down_counter #(
  parameter int WIDTH    = 64,
  parameter int PRESCALE = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Slt,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             AutoReload,
  output logic [WIDTH-1:0] Output0,
  output logic [WIDTH-1:0] Output1,
  output logic             Zero0,
  output logic             Zero1,
  output logic             Done0,
  output logic             Done1
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [WIDTH-1:0] reload0;
  logic [WIDTH-1:0] reload1;
  logic [PRE_W-1:0] pre;
  logic             pre_wrap;
  logic [WIDTH:0]   step0;
  logic [WIDTH:0]   step1;

  // Returns {done, next_count}; a zero count is idle so the channel never underflows.
  function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] cnt,
                                                input logic [WIDTH-1:0] rl,
                                                input logic             ar);
    logic [WIDTH:0] res;
    res = {1'b0, cnt};
    if (cnt == WIDTH'(1)) begin
      res = {1'b1, (ar ? rl : '0)};
    end else if (cnt != '0) begin
      res = {1'b0, cnt - WIDTH'(1)};
    end
    return res;
  endfunction

  always_comb begin
    step0    = count_step(Output0, reload0, AutoReload);
    step1    = count_step(Output1, reload1, AutoReload);
    pre_wrap = (pre == PRE_LAST);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Output0 <= '0;
      Output1 <= '0;
      reload0 <= '0;
      reload1 <= '0;
      pre     <= '0;
      Done0   <= 1'b0;
      Done1   <= 1'b0;
    end else begin
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      if (Load) begin
        if (!Slt) begin
          Output0 <= LoadValue;
          reload0 <= LoadValue;
        end else begin
          Output1 <= LoadValue;
          reload1 <= LoadValue;
          pre     <= '0;
        end
      end else if (En) begin
        if (!Slt) begin
          {Done0, Output0} <= step0;
        end else begin
          // The prescaler keeps running even when channel 1 is idle at zero.
          pre <= pre_wrap ? '0 : pre + PRE_W'(1);
          if (pre_wrap) begin
            {Done1, Output1} <= step1;
          end
        end
      end
    end
  end

  assign Zero0 = (Output0 == '0);
  assign Zero1 = (Output1 == '0);

endmodule

// File: tb/tb_dual_down_counter.sv
// Randomized and directed bench for dual_down_counter against an array-based channel model.
module tb_dual_down_counter;

  localparam int W  = 64;
  localparam int PS = 4;
  localparam logic [W-1:0] ALL1 = '1;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         En = 1'b0;
  logic         Slt = 1'b0;
  logic         Load = 1'b0;
  logic [W-1:0] LoadValue = '0;
  logic         AutoReload = 1'b0;
  logic [W-1:0] Output0, Output1;
  logic         Zero0, Zero1, Done0, Done1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-channel count/reload arrays and an enabled-cycle tally for channel 1
  logic [W-1:0] m_out [2];
  logic [W-1:0] m_rel [2];
  logic         m_done[2];
  int           m_pre;

  dual_down_counter #(.WIDTH(W), .PRESCALE(PS)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Load(Load),
    .LoadValue(LoadValue), .AutoReload(AutoReload),
    .Output0(Output0), .Output1(Output1), .Zero0(Zero0), .Zero1(Zero1),
    .Done0(Done0), .Done1(Done1)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_out[c] = '0; m_rel[c] = '0; m_done[c] = 1'b0;
    end
    m_pre = 0;
  endtask

  task automatic model_step(input logic en, input logic slt, input logic ld,
                            input logic [W-1:0] lv, input logic ar);
    int c;
    bit stepping;
    c = slt ? 1 : 0;
    m_done[0] = 1'b0;
    m_done[1] = 1'b0;
    if (ld) begin
      m_out[c] = lv;
      m_rel[c] = lv;
      if (c == 1) m_pre = 0;
    end else if (en) begin
      stepping = 1'b1;
      if (c == 1) begin
        m_pre = (m_pre + 1) % PS;
        stepping = (m_pre == 0);
      end
      if (stepping && m_out[c] != 0) begin
        if (m_out[c] == 1) begin
          m_done[c] = 1'b1;
          m_out[c]  = ar ? m_rel[c] : '0;
        end else begin
          m_out[c] = m_out[c] - 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic en, input logic slt, input logic ld,
                       input logic [W-1:0] lv, input logic ar);
    En = en; Slt = slt; Load = ld; LoadValue = lv; AutoReload = ar;
    @(posedge Clk);
    model_step(en, slt, ld, lv, ar);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    #12;
    n_tests++;
    if ({Output0, Output1} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h expected 0/0", Output0, Output1);
    end
    n_tests++;
    if ({Zero0, Zero1, Done0, Done1} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 1100", {Zero0, Zero1, Done0, Done1});
    end
    @(negedge Clk);
    Reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, W'(5), 1'b0);
    n_tests++;
    if (Output0 !== W'(5)) begin
      n_fail++; $display("FAIL load_before_async: got %0d expected 5", Output0);
    end
    #2 Reset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (Output0 !== '0 || Zero0 !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got %0d zero=%b expected 0 zero=1", Output0, Zero0);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [W-1:0] exp_out;
    cycle(1'b1, 1'b0, 1'b1, W'(3), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      exp_out = (i < 3) ? W'(2 - i) : '0;
      n_tests++;
      if (Output0 !== exp_out || Done0 !== (i == 2) || Zero0 !== (exp_out == 0)) begin
        n_fail++;
        $display("FAIL oneshot[%0d]: got out=%0d done=%b zero=%b expected out=%0d done=%b",
                 i, Output0, Done0, Zero0, exp_out, (i == 2));
      end
    end
  endtask

  task automatic test_autoreload();
    logic [W-1:0] exp_out;
    cycle(1'b1, 1'b0, 1'b1, W'(2), 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      exp_out = (i % 2 == 0) ? W'(1) : W'(2);
      n_tests++;
      if (Output0 !== exp_out || Done0 !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL autoreload[%0d]: got out=%0d done=%b expected out=%0d done=%b",
                 i, Output0, Done0, exp_out, (i % 2 == 1));
      end
    end
  endtask

  task automatic test_prescale();
    logic [W-1:0] exp_out;
    cycle(1'b1, 1'b1, 1'b1, W'(2), 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      exp_out = (k < 4) ? W'(2) : (k < 8) ? W'(1) : W'(0);
      n_tests++;
      if (Output1 !== exp_out || Done1 !== (k == 8)) begin
        n_fail++;
        $display("FAIL prescale[%0d]: got out1=%0d done1=%b expected out1=%0d done1=%b",
                 k, Output1, Done1, exp_out, (k == 8));
      end
    end
    // Interleave three channel-0 cycles; channel 1 must resume exactly where it paused
    cycle(1'b1, 1'b1, 1'b1, W'(2), 1'b0);
    for (int k = 1; k <= 11; k++) begin
      if (k >= 6 && k <= 8) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      else                  cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      n_tests++;
      if (Done1 !== (k == 11) || Output1 !== ((k < 4) ? W'(2) : (k < 11) ? W'(1) : W'(0))) begin
        n_fail++;
        $display("FAIL prescale_gap[%0d]: got out1=%0d done1=%b expected done1=%b",
                 k, Output1, Done1, (k == 11));
      end
    end
  endtask

  task automatic test_load_priority();
    cycle(1'b1, 1'b1, 1'b1, W'(9), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, W'(7), 1'b0);
    n_tests++;
    if (Output0 !== W'(7) || Output1 !== W'(9)) begin
      n_fail++;
      $display("FAIL load_priority: got out0=%0d out1=%0d expected out0=7 out1=9", Output0, Output1);
    end
  endtask

  task automatic test_zero_and_max();
    cycle(1'b1, 1'b0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      n_tests++;
      if (Output0 !== '0 || Done0 !== 1'b0 || Zero0 !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_load[%0d]: got out0=%h done0=%b expected out0=0 done0=0", i, Output0, Done0);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, ALL1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_tests++;
    if (Output0 !== ALL1 - 1) begin
      n_fail++; $display("FAIL max_load0: got %h expected %h", Output0, ALL1 - 1);
    end
    cycle(1'b1, 1'b1, 1'b1, ALL1, 1'b0);
    for (int i = 0; i < PS; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    n_tests++;
    if (Output1 !== ALL1 - 1) begin
      n_fail++; $display("FAIL max_load1: got %h expected %h", Output1, ALL1 - 1);
    end
  endtask

  task automatic test_random();
    logic         en, slt, ld, ar;
    logic [W-1:0] lv;
    logic [W-1:0] e0, e1;
    int           bad = 0;
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 9) < 8);
      slt = $urandom_range(0, 1);
      ld  = ($urandom_range(0, 9) == 0);
      ar  = $urandom_range(0, 1);
      lv  = ($urandom_range(0, 15) == 0) ? ALL1 : W'($urandom_range(0, 6));
      cycle(en, slt, ld, lv, ar);
      e0 = m_out[0];
      e1 = m_out[1];
      n_tests++;
      if (Output0 !== e0 || Output1 !== e1 || Zero0 !== (e0 == 0) || Zero1 !== (e1 == 0) ||
          Done0 !== m_done[0] || Done1 !== m_done[1]) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: got %h/%h d=%b%b z=%b%b expected %h/%h d=%b%b",
                   i, Output0, Output1, Done0, Done1, Zero0, Zero1, e0, e1, m_done[0], m_done[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_prescale();
    test_load_priority();
    test_zero_and_max();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_down_counter.md
Name: dual_down_counter

Overview:
- Dual-channel down-counter. It is the count-down counterpart of the team's up-counting event counter.
- Software loads a start value into one channel. That channel then counts down to zero and signals termination.
- Channel 0 steps on every enabled cycle. Channel 1 steps once per PRESCALE enabled cycles.
- Used as the timeout/terminal-count source alongside the up-counter in the same datapath.

Parameters:
- WIDTH, 64, width of each counter, load value and reload register.
- PRESCALE, 4, number of enabled channel-1 cycles per channel-1 step (must be >= 1; 1 disables prescaling).

Ports:
- Clk  input  1  clock; all state updates on posedge Clk.
- Reset  input  1  asynchronous, active-high reset.
- En  input  1  count enable.
- Slt  input  1  channel select: 0 = channel 0, 1 = channel 1. Applies to load and to counting.
- Load  input  1  load LoadValue into the selected channel.
- LoadValue  input  WIDTH  start/reload value.
- AutoReload  input  1  1 = periodic mode, 0 = one-shot mode. Sampled at each terminal step.
- Output0  output  WIDTH  channel 0 current count (registered).
- Output1  output  WIDTH  channel 1 current count (registered).
- Zero0  output  1  combinational: Output0 == 0.
- Zero1  output  1  combinational: Output1 == 0.
- Done0  output  1  registered one-cycle pulse marking a channel 0 terminal step.
- Done1  output  1  registered one-cycle pulse marking a channel 1 terminal step.

Behaviour:
- Reset (asynchronous, immediate):
  - Output0, Output1, Reload0, Reload1, the prescaler count Pre and Done0/Done1 all go to 0.
  - Zero0 = Zero1 = 1 during and after reset until a load.
- Priority each posedge: Reset > Load > En. Only the channel selected by Slt is affected. The other channel and its prescaler hold.
- Load=1 (En ignored):
  - Slt=0: Output0 <= LoadValue and Reload0 <= LoadValue.
  - Slt=1: Output1 <= LoadValue, Reload1 <= LoadValue and Pre <= 0.
  - Done of that channel <= 0.
- En=1, Load=0, Slt=0 (channel 0 step):
  - Output0 == 0: hold, Done0 <= 0.
  - Output0 == 1 (terminal step): Done0 <= 1. Output0 <= Reload0 if AutoReload=1, else 0. Reload0 = 1 with AutoReload gives Done0 on every enabled cycle.
  - Output0 > 1: Output0 <= Output0 - 1, Done0 <= 0.
- En=1, Load=0, Slt=1 (channel 1):
  - Pre advances on every such cycle and wraps at PRESCALE-1, even when Output1 == 0.
  - On the wrap cycle (Pre == PRESCALE-1), channel 1 applies the channel 0 step rules using Output1, Reload1 and Done1.
  - On non-wrap cycles, Output1 holds and Done1 <= 0.
- Done timing: DoneN is high exactly in the cycle following the edge at which the terminal step occurred. On every other edge it returns to 0, including edges where En=0 or the other channel is selected.
- Periods:
  - One-shot: load N into channel 0, then N enabled channel-0 cycles until Output0 = 0 and Done0 pulses once.
  - Channel 1 takes N*PRESCALE enabled channel-1 cycles.
  - AutoReload with N >= 1: Done pulses every N (channel 0) or N*PRESCALE (channel 1) enabled cycles.
- Zero count: loading 0 leaves the channel idle. No decrement, no Done, no underflow wrap.
- No underflow: Output never wraps below 0, even with all-ones LoadValue.
- Reset mid-count: Reset asserted mid-count clears the channel immediately. Any pending Done is dropped.
- En=0: all state holds. Done0 and Done1 <= 0.

Test Plan:
- Reset → all outputs 0 and Zero0 = Zero1 = 1. Asserting Reset between clock edges clears Output0 = 5 to 0 without waiting for an edge.
- Load 3 to ch0 (Slt=0), AutoReload=0, En=1 → Output0 = 2, 1, 0 on the next 3 edges. Done0 = 1 only in the cycle after Output0 becomes 0. Output0 then stays 0 with no further Done0.
- Load 2 to ch0, AutoReload=1, En=1 for 8 cycles → Output0 sequence is 1, 2, 1, 2, … and Done0 pulses on every 2nd cycle.
- Load 2 to ch1 (Slt=1), PRESCALE=4, En=1 → Output1 = 1 after 4 enabled cycles and 0 after 8. Done1 pulses once, the cycle after the 8th. Toggling Slt to 0 for 3 cycles mid-count delays this by exactly 3 cycles.
- Load with En=1 on the same edge, Load=1 Slt=0 LoadValue=7 → Output0 = 7, not 6. Output1 is unchanged.
- Load 0 with AutoReload=1 → channel stays 0 with no Done. Load 2^WIDTH-1 → first step gives 2^WIDTH-2 (no wrap).
